// File: rtl/mux_rr_arb.sv
// Round-robin merge of NUM_CH valid/ready channels onto one registered output stream.
// Optional tag check (drop of words whose tag field disagrees with the grant) enabled by MUX_TAG_CHECK_EN.
module mux_rr_arb #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 12,
    parameter int CNT_W  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            in_valid,
    input  logic [NUM_CH*DATA_W-1:0]     in_data,
    output logic [NUM_CH-1:0]            in_ready,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(NUM_CH)-1:0]    out_ch,
    input  logic                         out_ready,
    output logic [CNT_W-1:0]             drop_cnt
);
    localparam int TAG_W = $clog2(NUM_CH);

    logic [TAG_W-1:0]  ptr_q, ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [TAG_W-1:0]  out_ch_q, out_ch_d;

    logic              ld;
    logic              any_req;
    logic              take;
    logic              tag_ok;
    logic [TAG_W-1:0]  gnt;
    logic [TAG_W-1:0]  idx;
    logic [DATA_W-1:0] word;

    // Descending scan so the channel closest to ptr (k=0) is the last writer and wins.
    always_comb begin
        any_req = 1'b0;
        gnt     = '0;
        idx     = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = ptr_q + TAG_W'(k);
            if (in_valid[idx]) begin
                any_req = 1'b1;
                gnt     = idx;
            end
        end
    end

    assign ld   = !out_valid_q || out_ready;
    assign take = any_req && ld && !reset;
    assign word = in_data[int'(gnt)*DATA_W +: DATA_W];

    always_comb begin
        in_ready = '0;
        if (take) begin
            in_ready[gnt] = 1'b1;
        end
    end

`ifdef MUX_TAG_CHECK_EN
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign tag_ok = (word[DATA_W-1 -: TAG_W] == gnt);

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (take && !tag_ok) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign tag_ok   = 1'b1;
    assign drop_cnt = '0;
`endif

    // A dropped word still advances the pointer, exactly like a forwarded one.
    always_comb begin
        ptr_d       = take ? gnt + 1'b1 : ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (ld) begin
            out_valid_d = take && tag_ok;
            if (take && tag_ok) begin
                out_data_d = word;
                out_ch_d   = gnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Directed-vector bench for mux_rr_arb (4 channels, 12-bit words, 2-bit drop counter).
module tb_mux_rr_arb;
`ifdef MUX_TAG_CHECK_EN
    localparam bit TC = 1'b1;
`else
    localparam bit TC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_valid;
    logic [47:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [11:0] out_data;
    logic [1:0]  out_ch;
    logic        out_ready;
    logic [1:0]  drop_cnt;

    mux_rr_arb #(.NUM_CH(4), .DATA_W(12), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ch(out_ch), .out_ready(out_ready), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [47:0] data;
        logic        ordy;
        logic [3:0]  rdy;
        logic        ov;
        logic [11:0] od;
        logic [1:0]  oc;
        logic [1:0]  dc;
    } vec_t;

    vec_t tv[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic r, logic [3:0] v, logic [47:0] d, logic o,
                                logic [3:0] er, logic eov, logic [11:0] eod,
                                logic [1:0] eoc, logic [1:0] edc);
        vec_t t;
        t.rst = r; t.vld = v; t.data = d; t.ordy = o;
        t.rdy = er; t.ov = eov; t.od = eod; t.oc = eoc; t.dc = edc;
        return t;
    endfunction

    task automatic chk(input string name, input int id, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int id);
        @(negedge clk);
        reset = t.rst; in_valid = t.vld; in_data = t.data; out_ready = t.ordy;
        #1;
        chk("in_ready", id, {12'd0, in_ready}, {12'd0, t.rdy});
        @(posedge clk);
        #1;
        chk("out_valid", id, {15'd0, out_valid}, {15'd0, t.ov});
        chk("out_data", id, {4'd0, out_data}, {4'd0, t.od});
        chk("out_ch", id, {14'd0, out_ch}, {14'd0, t.oc});
        chk("drop_cnt", id, {14'd0, drop_cnt}, {14'd0, t.dc});
    endtask

    logic [11:0] w [4];
    logic [47:0] dd, d_tag, d_one, d_zero, d_bad;

    initial begin
        w[0] = 12'h0A0; w[1] = 12'h4B1; w[2] = 12'h855; w[3] = 12'hC33;
        dd     = {w[3], w[2], w[1], w[0]};
        d_tag  = {w[3], w[2], w[1], 12'hC01};
        d_one  = {w[3], w[2], w[1], 12'h001};
        d_zero = {w[3], w[2], w[1], 12'h000};
        d_bad  = {w[3], 12'h111, w[1], w[0]};
        reset = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;

        // reset, idle, single channel
        tv.push_back(mk(1'b1, 4'b0000, dd, 1'b0, 4'b0000, 1'b0, 12'h000, 2'd0, 2'd0));
        tv.push_back(mk(1'b1, 4'b0000, dd, 1'b0, 4'b0000, 1'b0, 12'h000, 2'd0, 2'd0));
        tv.push_back(mk(1'b0, 4'b0000, dd, 1'b1, 4'b0000, 1'b0, 12'h000, 2'd0, 2'd0));
        tv.push_back(mk(1'b0, 4'b0100, dd, 1'b1, 4'b0100, 1'b1, 12'h855, 2'd2, 2'd0));
        tv.push_back(mk(1'b0, 4'b0000, dd, 1'b1, 4'b0000, 1'b0, 12'h855, 2'd2, 2'd0));
        tv.push_back(mk(1'b1, 4'b0000, dd, 1'b1, 4'b0000, 1'b0, 12'h000, 2'd0, 2'd0));
        // round robin, all channels requesting
        tv.push_back(mk(1'b0, 4'b1111, dd, 1'b1, 4'b0001, 1'b1, 12'h0A0, 2'd0, 2'd0));
        tv.push_back(mk(1'b0, 4'b1111, dd, 1'b1, 4'b0010, 1'b1, 12'h4B1, 2'd1, 2'd0));
        tv.push_back(mk(1'b0, 4'b1111, dd, 1'b1, 4'b0100, 1'b1, 12'h855, 2'd2, 2'd0));
        tv.push_back(mk(1'b0, 4'b1111, dd, 1'b1, 4'b1000, 1'b1, 12'hC33, 2'd3, 2'd0));
        tv.push_back(mk(1'b0, 4'b1111, dd, 1'b1, 4'b0001, 1'b1, 12'h0A0, 2'd0, 2'd0));
        // backpressure with ch1/ch3 pending, then release in order 1,3
        tv.push_back(mk(1'b0, 4'b1010, dd, 1'b0, 4'b0000, 1'b1, 12'h0A0, 2'd0, 2'd0));
        tv.push_back(mk(1'b0, 4'b1010, dd, 1'b0, 4'b0000, 1'b1, 12'h0A0, 2'd0, 2'd0));
        tv.push_back(mk(1'b0, 4'b1010, dd, 1'b0, 4'b0000, 1'b1, 12'h0A0, 2'd0, 2'd0));
        tv.push_back(mk(1'b0, 4'b1010, dd, 1'b1, 4'b0010, 1'b1, 12'h4B1, 2'd1, 2'd0));
        tv.push_back(mk(1'b0, 4'b1000, dd, 1'b1, 4'b1000, 1'b1, 12'hC33, 2'd3, 2'd0));
        tv.push_back(mk(1'b0, 4'b0000, dd, 1'b1, 4'b0000, 1'b0, 12'hC33, 2'd3, 2'd0));
        // tag mismatch on ch0, then a matching word, then a zero word
        tv.push_back(mk(1'b0, 4'b0001, d_tag, 1'b1, 4'b0001, !TC, TC ? 12'hC33 : 12'hC01,
                        TC ? 2'd3 : 2'd0, TC ? 2'd1 : 2'd0));
        tv.push_back(mk(1'b0, 4'b0001, d_one, 1'b1, 4'b0001, 1'b1, 12'h001, 2'd0, TC ? 2'd1 : 2'd0));
        tv.push_back(mk(1'b0, 4'b0001, d_zero, 1'b1, 4'b0001, 1'b1, 12'h000, 2'd0, TC ? 2'd1 : 2'd0));
        // five mismatched words from ch2: counter saturates at 3
        tv.push_back(mk(1'b0, 4'b0100, d_bad, 1'b1, 4'b0100, !TC, TC ? 12'h000 : 12'h111,
                        TC ? 2'd0 : 2'd2, TC ? 2'd2 : 2'd0));
        for (int i = 0; i < 4; i++)
            tv.push_back(mk(1'b0, 4'b0100, d_bad, 1'b1, 4'b0100, !TC, TC ? 12'h000 : 12'h111,
                            TC ? 2'd0 : 2'd2, TC ? 2'd3 : 2'd0));
        // load a word (ptr -> 3), reset mid-stream, then grant restarts at ch0
        tv.push_back(mk(1'b0, 4'b0100, dd, 1'b1, 4'b0100, 1'b1, 12'h855, 2'd2, TC ? 2'd3 : 2'd0));
        tv.push_back(mk(1'b1, 4'b1111, dd, 1'b0, 4'b0000, 1'b0, 12'h000, 2'd0, 2'd0));
        tv.push_back(mk(1'b0, 4'b1111, dd, 1'b1, 4'b0001, 1'b1, 12'h0A0, 2'd0, 2'd0));

        for (int i = 0; i < tv.size(); i++) apply(tv[i], i);

        // fairness: ptr=1, all requesting, alternate stall cycles; grants must step 1,2,3,0,...
        begin
            int exp_ch = 1;
            logic [11:0] last = 12'h0A0;
            for (int c = 0; c < 10; c++) begin
                vec_t t;
                if (c % 3 == 2) begin
                    t = mk(1'b0, 4'b1111, dd, 1'b0, 4'b0000, 1'b1, last,
                           2'((exp_ch + 3) % 4), 2'd0);
                end else begin
                    t = mk(1'b0, 4'b1111, dd, 1'b1, 4'(1 << exp_ch), 1'b1, w[exp_ch],
                           2'(exp_ch), 2'd0);
                    last   = w[exp_ch];
                    exp_ch = (exp_ch + 1) % 4;
                end
                t.dc = TC ? 2'd0 : 2'd0;
                apply(t, 100 + c);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
